// File: rtl/key_irq_ctrl_if.sv
// rtl/key_irq_ctrl_if.sv - register bus between system bridge and key_irq_ctrl
interface key_irq_ctrl_if;
  logic [2:0]  Addr;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;

  // bridge side drives address/write, receives read data
  modport master (output Addr, output WE, output WD, input RD);
  // device side
  modport slave (input Addr, input WE, input WD, output RD);
endinterface

// File: rtl/key_irq_ctrl.sv
// rtl/key_irq_ctrl.sv - debounced user-key device with edge capture and maskable IRQ (optional press counter: KEY_IRQ_PRESS_CNT_EN)
module key_irq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic              CLK,
  input  logic              RST,
  key_irq_ctrl_if.slave     bus,
  input  logic [7:0]        user_key,
  output logic              IRQ
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [7:0]    sync1;
  logic [7:0]    sync2;
  logic [7:0]    stable;
  logic [7:0]    stable_nxt;
  logic [CW-1:0] cnt     [8];
  logic [CW-1:0] cnt_nxt [8];

  logic [7:0] imask;
  logic [7:0] pend;
  logic [1:0] ctrl;
  logic [7:0] press;
  logic [7:0] release_ev;
  logic [7:0] edge_set;
  logic [7:0] pend_clr;

  logic wr_imask;
  logic wr_pend;
  logic wr_ctrl;

  // only the low byte of write data carries register content
  logic unused_wd;
  assign unused_wd = ^bus.WD[31:8];

  assign wr_imask = bus.WE && (bus.Addr == 3'd1);
  assign wr_pend  = bus.WE && (bus.Addr == 3'd2);
  assign wr_ctrl  = bus.WE && (bus.Addr == 3'd3);

  // two-flop synchronizer; inverted so 1 means pressed
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ~user_key;
      sync2 <= sync1;
    end
  end

  // per-key debounce: accept the new level only after it has differed for DEBOUNCE_CYCLES cycles
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < 8; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // debounce state registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stable <= '0;
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable <= stable_nxt;
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // edge selection; a new edge overrides a same-cycle write-1-to-clear
  always_comb begin
    press      = stable_nxt & ~stable;
    release_ev = stable & ~stable_nxt;
    edge_set   = ctrl[1] ? release_ev : press;
    pend_clr   = wr_pend ? bus.WD[7:0] : 8'h00;
  end

  // control/status registers and registered interrupt output
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      imask <= '0;
      ctrl  <= '0;
      pend  <= '0;
      IRQ   <= 1'b0;
    end else begin
      if (wr_imask) imask <= bus.WD[7:0];
      if (wr_ctrl)  ctrl  <= bus.WD[1:0];
      pend <= (pend & ~pend_clr) | edge_set;
      IRQ  <= ctrl[0] & (|(pend & imask));
    end
  end

`ifdef KEY_IRQ_PRESS_CNT_EN
  logic [31:0] press_cnt;
  logic [3:0]  press_num;
  logic        wr_cnt;

  assign wr_cnt = bus.WE && (bus.Addr == 3'd4);

  // number of keys accepting a press this cycle
  always_comb begin
    press_num = 4'd0;
    for (int i = 0; i < 8; i++) begin
      press_num = press_num + {3'b000, press[i]};
    end
  end

  // global press counter; a clearing write drops a same-cycle increment
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      press_cnt <= '0;
    end else if (wr_cnt) begin
      press_cnt <= '0;
    end else begin
      press_cnt <= press_cnt + {28'd0, press_num};
    end
  end
`endif

  // combinational read mux; unmapped indices read 0
  always_comb begin
    bus.RD = '0;
    case (bus.Addr)
      3'd0: bus.RD[7:0] = stable;
      3'd1: bus.RD[7:0] = imask;
      3'd2: bus.RD[7:0] = pend;
      3'd3: bus.RD[1:0] = ctrl;
`ifdef KEY_IRQ_PRESS_CNT_EN
      3'd4: bus.RD      = press_cnt;
`endif
      default: bus.RD = '0;
    endcase
  end

endmodule

// File: tb/tb_key_irq_ctrl.sv
// tb/tb_key_irq_ctrl.sv - directed self-checking bench for key_irq_ctrl
module tb_key_irq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] user_key;
  logic       irq;
  int         n_checks;
  int         n_pass;

  key_irq_ctrl_if bif ();

  key_irq_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK      (clk),
    .RST      (rst_n),
    .bus      (bif),
    .user_key (user_key),
    .IRQ      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // advance n rising edges, ending 1ns after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bif.Addr = a;
    bif.WE   = 1'b1;
    bif.WD   = d;
    @(posedge clk);
    #1;
    bif.WE   = 1'b0;
    bif.WD   = '0;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bif.Addr = a;
    #1;
    check(tag, bif.RD, exp);
  endtask

  logic [31:0] cnt_exp2;
  logic [31:0] cnt_exp3;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    user_key = 8'hFF;
    bif.Addr = '0;
    bif.WE   = 1'b0;
    bif.WD   = '0;
`ifdef KEY_IRQ_PRESS_CNT_EN
    cnt_exp2 = 32'd2;
    cnt_exp3 = 32'd3;
`else
    cnt_exp2 = 32'd0;
    cnt_exp3 = 32'd0;
`endif

    // reset: every index reads 0, IRQ low
    tick(3);
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      read_check($sformatf("rst_rd%0d", i), 3'(i), 32'h0);
      tick(1);
    end
    check("rst_irq", {31'd0, irq}, 32'd0);

    // press key 0 with EN=1, IMASK=1; stable/PEND at k+6, IRQ at k+7
    bus_write(3'd3, 32'h1);
    bus_write(3'd1, 32'h1);
    read_check("imask_rd", 3'd1, 32'h1);
    read_check("ctrl_rd", 3'd3, 32'h1);
    tick(1);
    user_key[0] = 1'b0;
    tick(5);
    read_check("k0_state_k5", 3'd0, 32'h0);
    tick(1);
    read_check("k0_state_k6", 3'd0, 32'h1);
    read_check("k0_pend_k6", 3'd2, 32'h1);
    check("k0_irq_k6", {31'd0, irq}, 32'd0);
    tick(1);
    check("k0_irq_k7", {31'd0, irq}, 32'd1);
    bus_write(3'd2, 32'h1);
    read_check("k0_pend_clr", 3'd2, 32'h0);
    check("k0_irq_wedge", {31'd0, irq}, 32'd1);
    tick(1);
    check("k0_irq_dropped", {31'd0, irq}, 32'd0);

    // 3-cycle glitch on key 3 is rejected
    user_key[3] = 1'b0;
    tick(3);
    user_key[3] = 1'b1;
    tick(10);
    read_check("glitch_state", 3'd0, 32'h1);
    read_check("glitch_pend", 3'd2, 32'h0);
    check("glitch_irq", {31'd0, irq}, 32'd0);

    // release capture on key 5
    bus_write(3'd3, 32'h3);
    bus_write(3'd1, 32'hFF);
    user_key[5] = 1'b0;
    tick(6);
    read_check("rel_state_press", 3'd0, 32'h21);
    read_check("rel_pend_press", 3'd2, 32'h0);
    user_key[5] = 1'b1;
    tick(6);
    read_check("rel_state_release", 3'd0, 32'h01);
    read_check("rel_pend_release", 3'd2, 32'h20);
    tick(1);
    check("rel_irq", {31'd0, irq}, 32'd1);
    bus_write(3'd2, 32'hFF);
    tick(1);
    check("rel_irq_clr", {31'd0, irq}, 32'd0);

    // toggling EDGE alone sets nothing
    bus_write(3'd3, 32'h0);
    read_check("edge_toggle_pend", 3'd2, 32'h0);

    // EN=0 with press pending, then enable
    user_key[5] = 1'b0;
    tick(6);
    read_check("en0_pend", 3'd2, 32'h20);
    tick(2);
    check("en0_irq", {31'd0, irq}, 32'd0);
    bus_write(3'd3, 32'h1);
    check("en1_irq_wedge", {31'd0, irq}, 32'd0);
    tick(1);
    check("en1_irq", {31'd0, irq}, 32'd1);
    user_key[5] = 1'b1;
    tick(8);
    bus_write(3'd2, 32'hFF);
    tick(1);
    check("en1_irq_clr", {31'd0, irq}, 32'd0);

    // writes to STATE and unmapped indices are ignored
    bus_write(3'd0, 32'hFF);
    bus_write(3'd6, 32'hFFFF_FFFF);
    read_check("ro_state", 3'd0, 32'h01);
    read_check("rd_idx6", 3'd6, 32'h0);

    // press counter: keys 1 and 2 together, then key 1 again
    bus_write(3'd4, 32'h0);
    read_check("cnt_clr0", 3'd4, 32'h0);
    user_key[2:1] = 2'b00;
    tick(6);
    read_check("cnt_two", 3'd4, cnt_exp2);
    read_check("dual_state", 3'd0, 32'h07);
    user_key[1] = 1'b1;
    tick(6);
    user_key[1] = 1'b0;
    tick(6);
    read_check("cnt_three", 3'd4, cnt_exp3);
    bus_write(3'd4, 32'h0);
    read_check("cnt_cleared", 3'd4, 32'h0);

    // clear and press land on the same edge: set wins
    bus_write(3'd3, 32'h0);
    bus_write(3'd2, 32'hFF);
    read_check("sw_pre", 3'd2, 32'h0);
    user_key[6] = 1'b0;
    tick(5);
    bus_write(3'd2, 32'h40);
    read_check("set_wins", 3'd2, 32'h40);

    // reset mid-debounce on key 7; held keys need a full debounce afterwards
    user_key[7] = 1'b0;
    tick(3);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    read_check("rst2_state_r5", 3'd0, 32'h0);
    read_check("rst2_pend_r5", 3'd2, 32'h0);
    tick(1);
    read_check("rst2_state_r6", 3'd0, 32'hC7);
    read_check("rst2_pend_r6", 3'd2, 32'hC7);
    check("rst2_irq", {31'd0, irq}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
